// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - SM4 shared constants, S-box table, rotate/L' helpers and key-schedule FSM state
package sm4_pkg;

    localparam logic [31:0] SM4_FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    typedef enum logic {IDLE, RUN} sm4_state_t;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] sm4_rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] sm4_lprime(input logic [31:0] b);
        return b ^ sm4_rotl(b, 5'd13) ^ sm4_rotl(b, 5'd23);
    endfunction

endpackage

// File: rtl/get_cki.sv
// rtl/get_cki.sv - SM4 round constant CK_i; byte j of CK_i is (4i+j)*7 mod 256
module get_cki (
    input  logic [4:0]  idx,
    output logic [31:0] cki
);

    logic [7:0] base;

    assign base       = {1'b0, idx, 2'b00};
    assign cki[31:24] = base * 8'd7;
    assign cki[23:16] = (base + 8'd1) * 8'd7;
    assign cki[15:8]  = (base + 8'd2) * 8'd7;
    assign cki[7:0]   = (base + 8'd3) * 8'd7;

endmodule

// File: rtl/sm4_sbox.sv
// rtl/sm4_sbox.sv - single 8-bit SM4 S-box lookup
module sm4_sbox
    import sm4_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SM4_SBOX[din];

endmodule

// File: rtl/sm4_key_expand.sv
// rtl/sm4_key_expand.sv - iterative SM4 key schedule, one round key per handshake; SM4_RK_STORE_EN adds a readable rk table
module sm4_key_expand #(
    parameter int NUM_RND = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [127:0] key_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [31:0]  rk_o,
    output logic [4:0]   rk_idx_o,
    output logic         done_o
`ifdef SM4_RK_STORE_EN
    ,
    input  logic [4:0]   rk_rd_idx_i,
    output logic [31:0]  rk_rd_o,
    output logic         rk_tbl_vld_o
`endif
);

    import sm4_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(NUM_RND - 1);

    sm4_state_t  state_q, state_d;
    logic [31:0] k0_q, k1_q, k2_q, k3_q;
    logic [4:0]  ctr_q;
    logic        done_q;
    logic [31:0] ck, mix, tau, rk;
    logic        accept, hs, last_hs;

    get_cki u_get_cki (
        .idx (ctr_q),
        .cki (ck)
    );

    assign mix = k1_q ^ k2_q ^ k3_q ^ ck;

    for (genvar g = 0; g < 4; g++) begin : g_tau
        sm4_sbox u_sbox (
            .din  (mix[8*g +: 8]),
            .dout (tau[8*g +: 8])
        );
    end

    assign rk      = k0_q ^ sm4_lprime(tau);
    assign accept  = key_valid_i & key_ready_o;
    assign hs      = rk_valid_o & rk_ready_i;
    assign last_hs = hs & (ctr_q == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            ctr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_hs;
            if (accept) begin
                k0_q  <= key_i[127:96] ^ SM4_FK[0];
                k1_q  <= key_i[95:64]  ^ SM4_FK[1];
                k2_q  <= key_i[63:32]  ^ SM4_FK[2];
                k3_q  <= key_i[31:0]   ^ SM4_FK[3];
                ctr_q <= '0;
            end else if (hs) begin
                k0_q  <= k1_q;
                k1_q  <= k2_q;
                k2_q  <= k3_q;
                k3_q  <= rk;
                ctr_q <= ctr_q + 5'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = RUN;
            RUN:     if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_ready_o = 1'b0;
        rk_valid_o  = 1'b0;
        case (state_q)
            IDLE:    key_ready_o = 1'b1;
            RUN:     rk_valid_o  = 1'b1;
            default: key_ready_o = 1'b0;
        endcase
    end

    assign rk_o     = rk;
    assign rk_idx_o = ctr_q;
    assign done_o   = done_q;

`ifdef SM4_RK_STORE_EN
    logic [31:0] rk_tbl [NUM_RND];
    logic        tbl_vld_q;

    // Table contents need no reset; rk_tbl_vld_o gates their use.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            rk_tbl[ctr_q] <= rk;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tbl_vld_q <= 1'b0;
        end else if (last_hs) begin
            tbl_vld_q <= 1'b1;
        end else if (accept) begin
            tbl_vld_q <= 1'b0;
        end
    end

    assign rk_rd_o      = rk_tbl[rk_rd_idx_i];
    assign rk_tbl_vld_o = tbl_vld_q;
`endif

endmodule
